// File: rtl/int_controller.sv
// rtl/int_controller.sv - four-source rising-edge interrupt controller with round-robin arbitration
// One interrupt in service at a time; registered irq/int_vec/pend/busy outputs.
module int_controller #(
    parameter int          N_SRC    = 4,
    parameter logic [9:0]  VEC_BASE = 10'h3C0,
    parameter int          VEC_STEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] int_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_din,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             irq,
    output logic [9:0]       int_vec,
    output logic [N_SRC-1:0] pend,
    output logic             busy
);
    localparam int         IW     = $clog2(N_SRC);
    localparam logic [9:0] STEP10 = 10'(VEC_STEP);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t           state, state_nx;
    logic [N_SRC-1:0] src_d, mask, mask_nx, pend_nx, src_edge, elig, clr;
    logic [IW-1:0]    rr_ptr, rr_nx, sel, sel_nx, win, idx;
    logic             found, irq_nx, busy_nx;
    logic [9:0]       vec_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            src_d   <= '0;
            mask    <= '0;
            pend    <= '0;
            rr_ptr  <= '0;
            sel     <= '0;
            irq     <= 1'b0;
            int_vec <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            src_d   <= int_src;
            mask    <= mask_nx;
            pend    <= pend_nx;
            rr_ptr  <= rr_nx;
            sel     <= sel_nx;
            irq     <= irq_nx;
            int_vec <= vec_nx;
            busy    <= busy_nx;
        end
    end

    always_comb begin
        src_edge = int_src & ~src_d;
        elig     = pend & mask;
        win      = '0;
        idx      = '0;
        found    = 1'b0;
        // Search from rr_ptr upward, wrapping; first eligible index wins.
        for (int i = 0; i < N_SRC; i++) begin
            idx = rr_ptr + IW'(i);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end

        state_nx = state;
        sel_nx   = sel;
        rr_nx    = rr_ptr;
        irq_nx   = irq;
        vec_nx   = int_vec;
        busy_nx  = busy;
        clr      = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = REQ;
                    sel_nx   = win;
                    irq_nx   = 1'b1;
                    vec_nx   = VEC_BASE + 10'(win) * STEP10;
                end
            end
            REQ: begin
                if (int_ack) begin
                    clr[sel] = 1'b1;
                    state_nx = SERV;
                    irq_nx   = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            SERV: begin
                if (eoi) begin
                    rr_nx    = sel + 1'b1;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                irq_nx   = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase

        // Clear before set so an edge coinciding with its own ack keeps the flag.
        pend_nx = (pend & ~clr) | src_edge;
        mask_nx = mask_we ? mask_din : mask;
    end
endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - randomized scoreboard bench for int_controller
module tb_int_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] int_src = '0, mask_din = '0;
    logic       mask_we = 1'b0, int_ack = 1'b0, eoi = 1'b0;
    logic       irq0, busy0, irq1, busy1;
    logic [9:0] vec0, vec1;
    logic [3:0] pend0, pend1;

    always #5 clk = ~clk;

    int_controller dut0 (
        .clk(clk), .reset(reset), .int_src(int_src), .mask_we(mask_we), .mask_din(mask_din),
        .int_ack(int_ack), .eoi(eoi), .irq(irq0), .int_vec(vec0), .pend(pend0), .busy(busy0)
    );

    int_controller #(.VEC_BASE(10'h3F8)) dut1 (
        .clk(clk), .reset(reset), .int_src(int_src), .mask_we(mask_we), .mask_din(mask_din),
        .int_ack(int_ack), .eoi(eoi), .irq(irq1), .int_vec(vec1), .pend(pend1), .busy(busy1)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; bit [3:0] pend; bit busy; bit irq; } stat_t;
    typedef struct { int cyc; int src; } ev_t;
    stat_t stat_q[$];
    ev_t   ev_q[$];

    // Reference model: phase 0 idle, 1 requesting, 2 in service.
    bit [3:0] m_pend, m_mask, m_prev;
    int       m_rr, m_sel, m_phase;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_rr = 0; m_sel = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit [3:0] s, input bit mwe, input bit [3:0] md,
                              input bit a, input bit e);
        bit [3:0] rise;
        bit       got;
        rise   = s & ~m_prev;
        m_prev = s;
        got    = 1'b0;
        if (m_phase == 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_rr + k) % 4;
                if (!got && m_pend[j] && m_mask[j]) begin
                    got     = 1'b1;
                    m_sel   = j;
                    m_phase = 1;
                    ev_q.push_back('{cyc + 1, j});
                end
            end
        end else if (m_phase == 1 && a) begin
            m_pend[m_sel] = 1'b0;
            m_phase       = 2;
        end else if (m_phase == 2 && e) begin
            m_rr    = (m_sel + 1) % 4;
            m_phase = 0;
        end
        m_pend = m_pend | rise;
        if (mwe) m_mask = md;
        stat_q.push_back('{cyc + 1, m_pend, m_phase == 2, m_phase == 1});
    endtask

    task automatic cycle(input bit [3:0] s, input bit mwe = 0, input bit [3:0] md = 0,
                         input bit a = 0, input bit e = 0);
        int_src = s; mask_we = mwe; mask_din = md; int_ack = a; eoi = e;
        model_step(s, mwe, md, a, e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit [3:0] s, input bit mid);
        reset = 1'b0;
        stat_q.delete();
        ev_q.delete();
        model_clear();
        #1;
        if (mid) begin
            chk("async_busy", busy0, 0);
            chk("async_irq", irq0, 0);
        end
        int_src = s; mask_we = 0; int_ack = 0; eoi = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pend", pend0, 0);
        chk("rst_irq", irq0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_vec", vec0, 0);
        reset = 1'b1;
        #1;
        chk("rel_pend", pend0, 0);
        chk("rel_irq", irq0, 0);
        chk("rel_busy", busy0, 0);
    endtask

    bit irq_prev = 1'b0;
    always @(negedge clk) begin
        if (reset && stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
            stat_t st;
            st = stat_q.pop_front();
            chk("pend", pend0, st.pend);
            chk("busy", busy0, st.busy);
            chk("irq", irq0, st.irq);
        end
        if (reset && irq0 && !irq_prev) begin
            if (ev_q.size() == 0) begin
                chk("irq_unexpected", 1, 0);
            end else begin
                ev_t ev;
                ev = ev_q.pop_front();
                chk("irq_cycle", cyc, ev.cyc);
                chk("vec", vec0, (32'h3C0 + 8 * ev.src) % 1024);
                chk("vec_wrap", vec1, (32'h3F8 + 8 * ev.src) % 1024);
            end
        end
        irq_prev = irq0;
    end

    initial begin
        bit [3:0] s;
        model_clear();
        apply_reset(4'($urandom), 0);
        cycle(int_src);
        cycle(int_src);
        apply_reset(4'h0, 0);

        // Single event on source 2.
        cycle(4'h0, 1, 4'hF);
        cycle(4'h4);
        cycle(4'h4);
        cycle(4'h4);
        cycle(4'h4, 0, 0, 1, 0);
        cycle(4'h0);
        cycle(4'h0, 0, 0, 0, 1);

        // Simultaneous sources 0 and 1, served back to back.
        cycle(4'h3);
        cycle(4'h3);
        cycle(4'h3, 0, 0, 1, 0);
        cycle(4'h0, 0, 0, 0, 1);
        cycle(4'h0);
        cycle(4'h0, 0, 0, 1, 0);
        cycle(4'h0, 0, 0, 0, 1);
        cycle(4'h0);

        // Masked source 0 released by a later mask write.
        cycle(4'h0, 1, 4'hE);
        cycle(4'h1);
        cycle(4'h1);
        cycle(4'h1);
        cycle(4'h1, 1, 4'hF);
        cycle(4'h1);
        cycle(4'h1, 0, 0, 1, 0);
        cycle(4'h0, 0, 0, 0, 1);

        // Edge on source 3 coinciding with its ack, then spurious handshakes.
        cycle(4'h8);
        cycle(4'h8);
        cycle(4'h0);
        cycle(4'h8, 0, 0, 1, 0);
        cycle(4'h0, 0, 0, 1, 0);
        cycle(4'h0, 0, 0, 0, 1);
        cycle(4'h0);
        cycle(4'h0, 0, 0, 1, 1);
        cycle(4'h0, 0, 0, 0, 1);
        cycle(4'h0, 0, 0, 0, 1);
        cycle(4'h0);

        // Asynchronous reset while in service.
        cycle(4'h2);
        cycle(4'h2);
        cycle(4'h2, 0, 0, 1, 0);
        cycle(4'h2);
        apply_reset(4'h0, 1);

        for (int n = 0; n < 3000; n++) begin
            s = int_src ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            cycle(s, $urandom_range(0, 7) == 0, 4'($urandom | $urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        cycle(4'h0, 1, 4'hF);
        for (int n = 0; n < 24; n++) cycle(4'h0, 0, 0, n % 2 == 0, n % 2 == 1);
        @(negedge clk);
        #1;
        chk("ev_q_drained", ev_q.size(), 0);
        chk("stat_q_drained", stat_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
